reorder_buffer: RTL and testbench

//  In-order retirement buffer of the Tomasulo core; the producer of the commit/rollback interface the register file consumes.

---
 rtl/reorder_buffer.sv | 256 +++++++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer for the Tomasulo core.
//  - The dispatcher allocates one entry per cycle in program order at the tail tag.
//  - The CDB writes results back out of order, addressed by tag.
//  - The head retires one ready entry per cycle towards the register file.
//  - A mispredicted branch at commit flushes every entry and broadcasts a rollback.
//  - Operand queries by tag are answered combinationally.
// Tags run 1..DEPTH. Tag 0 means "no producer". Entry k always holds tag k.
// Optional feature: define ROB_BYPASS_EN to let operand queries see a
// result that the CDB is broadcasting in the same cycle.
//
// Handshake: an allocation takes effect at the clock edge where
// ena_from_dsp && !full_to_dsp holds and no rollback fires on that edge.
// Q_to_dsp is the tag that allocation receives. An ena while full is
// dropped, and the dispatcher must hold the instruction until full falls.
// The CDB has no back-pressure. A write to a non-busy tag is ignored.
module reorder_buffer #(
  parameter int ROB_ID_W = 4,
  parameter int DEPTH    = 15,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena_from_dsp,
  input  logic [4:0]          rd_from_dsp,
  input  logic                is_jump_from_dsp,
  input  logic                pred_jump_from_dsp,
  output logic [ROB_ID_W-1:0] Q_to_dsp,
  output logic                full_to_dsp,
  input  logic [ROB_ID_W-1:0] Q1_from_dsp,
  input  logic [ROB_ID_W-1:0] Q2_from_dsp,
  output logic                ready1_to_dsp,
  output logic                ready2_to_dsp,
  output logic [DATA_W-1:0]   V1_to_dsp,
  output logic [DATA_W-1:0]   V2_to_dsp,
  input  logic                valid_from_cdb,
  input  logic [ROB_ID_W-1:0] Q_from_cdb,
  input  logic [DATA_W-1:0]   V_from_cdb,
  input  logic                jump_from_cdb,
  input  logic [DATA_W-1:0]   pc_from_cdb,
  output logic                commit_flag_to_reg,
  output logic [4:0]          rd_to_reg,
  output logic [ROB_ID_W-1:0] Q_to_reg,
  output logic [DATA_W-1:0]   V_to_reg,
  output logic                rollback_flag_to_all,
  output logic [DATA_W-1:0]   target_pc_to_if
);

  // Storage is sized to the full tag space so that any tag indexes safely.
  // Slot 0 and any slot above DEPTH are never allocated, so they stay non-busy.
  localparam int SLOTS = 2 ** ROB_ID_W;
  localparam logic [ROB_ID_W-1:0] ONE_TAG  = ROB_ID_W'(1);
  localparam logic [ROB_ID_W-1:0] LAST_TAG = ROB_ID_W'(DEPTH);

  // Per-entry state
  logic [SLOTS-1:0]  busy_q, busy_d;
  logic [SLOTS-1:0]  ready_q, ready_d;
  logic [SLOTS-1:0]  ent_jump_q, ent_jump_d;
  logic [SLOTS-1:0]  ent_pred_q, ent_pred_d;
  logic [SLOTS-1:0]  ent_isj_q, ent_isj_d;
  logic [4:0]        ent_rd_q [SLOTS];
  logic [4:0]        ent_rd_d [SLOTS];
  logic [DATA_W-1:0] ent_v_q  [SLOTS];
  logic [DATA_W-1:0] ent_v_d  [SLOTS];
  logic [DATA_W-1:0] ent_pc_q [SLOTS];
  logic [DATA_W-1:0] ent_pc_d [SLOTS];

  // Pointers and occupancy
  logic [ROB_ID_W-1:0] head_q, head_d;
  logic [ROB_ID_W-1:0] tail_q, tail_d;
  logic [ROB_ID_W-1:0] count_q, count_d;

  // Registered commit/rollback interface
  logic                commit_flag_q, commit_flag_d;
  logic [4:0]          rd_to_reg_q, rd_to_reg_d;
  logic [ROB_ID_W-1:0] q_to_reg_q, q_to_reg_d;
  logic [DATA_W-1:0]   v_to_reg_q, v_to_reg_d;
  logic                rollback_q, rollback_d;
  logic [DATA_W-1:0]   target_pc_q, target_pc_d;

  logic wb_fire;
  logic commit_fire;
  logic mispredict;
  logic alloc_fire;

  // Tag counters wrap DEPTH -> 1 and never produce tag 0.
  function automatic logic [ROB_ID_W-1:0] next_tag(input logic [ROB_ID_W-1:0] t);
    if (t == LAST_TAG) return ONE_TAG;
    return t + ONE_TAG;
  endfunction

  assign full_to_dsp          = (count_q == LAST_TAG);
  assign Q_to_dsp             = tail_q;
  assign commit_flag_to_reg   = commit_flag_q;
  assign rd_to_reg            = rd_to_reg_q;
  assign Q_to_reg             = q_to_reg_q;
  assign V_to_reg             = v_to_reg_q;
  assign rollback_flag_to_all = rollback_q;
  assign target_pc_to_if      = target_pc_q;

  // Event decode. Commit looks only at registered entry state, so a result
  // written on this edge becomes committable on the next edge.
  always_comb begin
    wb_fire     = valid_from_cdb && (Q_from_cdb != '0) && busy_q[Q_from_cdb];
    commit_fire = busy_q[head_q] && ready_q[head_q];
    mispredict  = commit_fire && ent_isj_q[head_q] &&
                  (ent_jump_q[head_q] != ent_pred_q[head_q]);
    alloc_fire  = ena_from_dsp && !full_to_dsp && !mispredict;
  end

  // Next-state for the entries, pointers and registered outputs.
  // Order matters: writeback, then commit, then allocate, then flush overrides.
  always_comb begin
    busy_d        = busy_q;
    ready_d       = ready_q;
    ent_jump_d    = ent_jump_q;
    ent_pred_d    = ent_pred_q;
    ent_isj_d     = ent_isj_q;
    ent_rd_d      = ent_rd_q;
    ent_v_d       = ent_v_q;
    ent_pc_d      = ent_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    commit_flag_d = 1'b0;
    rd_to_reg_d   = rd_to_reg_q;
    q_to_reg_d    = q_to_reg_q;
    v_to_reg_d    = v_to_reg_q;
    rollback_d    = 1'b0;
    target_pc_d   = target_pc_q;

    if (wb_fire) begin
      ready_d[Q_from_cdb]    = 1'b1;
      ent_v_d[Q_from_cdb]    = V_from_cdb;
      ent_jump_d[Q_from_cdb] = jump_from_cdb;
      ent_pc_d[Q_from_cdb]   = pc_from_cdb;
    end

    if (commit_fire) begin
      commit_flag_d   = 1'b1;
      rd_to_reg_d     = ent_rd_q[head_q];
      q_to_reg_d      = head_q;
      v_to_reg_d      = ent_v_q[head_q];
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = next_tag(head_q);
    end

    if (alloc_fire) begin
      busy_d[tail_q]     = 1'b1;
      ready_d[tail_q]    = 1'b0;
      ent_rd_d[tail_q]   = rd_from_dsp;
      ent_isj_d[tail_q]  = is_jump_from_dsp;
      ent_pred_d[tail_q] = pred_jump_from_dsp;
      tail_d             = next_tag(tail_q);
    end

    case ({alloc_fire, commit_fire})
      2'b10:   count_d = count_q + ONE_TAG;
      2'b01:   count_d = count_q - ONE_TAG;
      default: count_d = count_q;
    endcase

    // The branch itself still retires. Everything younger is discarded.
    if (mispredict) begin
      busy_d      = '0;
      ready_d     = '0;
      head_d      = ONE_TAG;
      tail_d      = ONE_TAG;
      count_d     = '0;
      rollback_d  = 1'b1;
      target_pc_d = ent_pc_q[head_q];
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q        <= '0;
      ready_q       <= '0;
      ent_jump_q    <= '0;
      ent_pred_q    <= '0;
      ent_isj_q     <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        ent_rd_q[i] <= '0;
        ent_v_q[i]  <= '0;
        ent_pc_q[i] <= '0;
      end
      head_q        <= ONE_TAG;
      tail_q        <= ONE_TAG;
      count_q       <= '0;
      commit_flag_q <= 1'b0;
      rd_to_reg_q   <= '0;
      q_to_reg_q    <= '0;
      v_to_reg_q    <= '0;
      rollback_q    <= 1'b0;
      target_pc_q   <= '0;
    end else begin
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      ent_jump_q    <= ent_jump_d;
      ent_pred_q    <= ent_pred_d;
      ent_isj_q     <= ent_isj_d;
      for (int i = 0; i < SLOTS; i++) begin
        ent_rd_q[i] <= ent_rd_d[i];
        ent_v_q[i]  <= ent_v_d[i];
        ent_pc_q[i] <= ent_pc_d[i];
      end
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      commit_flag_q <= commit_flag_d;
      rd_to_reg_q   <= rd_to_reg_d;
      q_to_reg_q    <= q_to_reg_d;
      v_to_reg_q    <= v_to_reg_d;
      rollback_q    <= rollback_d;
      target_pc_q   <= target_pc_d;
    end
  end

  // Operand query 1: tag 0 is always ready with value 0; otherwise stored results
  always_comb begin
    ready1_to_dsp = 1'b0;
    V1_to_dsp     = '0;
    if (Q1_from_dsp == '0) begin
      ready1_to_dsp = 1'b1;
    end else if (busy_q[Q1_from_dsp] && ready_q[Q1_from_dsp]) begin
      ready1_to_dsp = 1'b1;
      V1_to_dsp     = ent_v_q[Q1_from_dsp];
    end
`ifdef ROB_BYPASS_EN
    else if (busy_q[Q1_from_dsp] && valid_from_cdb && (Q_from_cdb == Q1_from_dsp)) begin
      ready1_to_dsp = 1'b1;
      V1_to_dsp     = V_from_cdb;
    end
`endif
  end

  // Operand query 2: same rules as query 1
  always_comb begin
    ready2_to_dsp = 1'b0;
    V2_to_dsp     = '0;
    if (Q2_from_dsp == '0) begin
      ready2_to_dsp = 1'b1;
    end else if (busy_q[Q2_from_dsp] && ready_q[Q2_from_dsp]) begin
      ready2_to_dsp = 1'b1;
      V2_to_dsp     = ent_v_q[Q2_from_dsp];
    end
`ifdef ROB_BYPASS_EN
    else if (busy_q[Q2_from_dsp] && valid_from_cdb && (Q_from_cdb == Q2_from_dsp)) begin
      ready2_to_dsp = 1'b1;
      V2_to_dsp     = V_from_cdb;
    end
`endif
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: directed scenarios plus randomized traffic
// checked against a queue-based program-order model of the buffer.
module tb_reorder_buffer;
  localparam int ROB_ID_W = 4;
  localparam int DEPTH    = 15;
  localparam int DATA_W   = 32;
`ifdef ROB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                ena_from_dsp, is_jump_from_dsp, pred_jump_from_dsp;
  logic [4:0]          rd_from_dsp;
  logic [ROB_ID_W-1:0] Q_to_dsp, Q1_from_dsp, Q2_from_dsp, Q_from_cdb, Q_to_reg;
  logic                full_to_dsp, ready1_to_dsp, ready2_to_dsp;
  logic [DATA_W-1:0]   V1_to_dsp, V2_to_dsp, V_from_cdb, pc_from_cdb, V_to_reg, target_pc_to_if;
  logic                valid_from_cdb, jump_from_cdb, commit_flag_to_reg, rollback_flag_to_all;
  logic [4:0]          rd_to_reg;

  reorder_buffer #(.ROB_ID_W(ROB_ID_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .ena_from_dsp(ena_from_dsp), .rd_from_dsp(rd_from_dsp),
    .is_jump_from_dsp(is_jump_from_dsp), .pred_jump_from_dsp(pred_jump_from_dsp),
    .Q_to_dsp(Q_to_dsp), .full_to_dsp(full_to_dsp),
    .Q1_from_dsp(Q1_from_dsp), .Q2_from_dsp(Q2_from_dsp),
    .ready1_to_dsp(ready1_to_dsp), .ready2_to_dsp(ready2_to_dsp),
    .V1_to_dsp(V1_to_dsp), .V2_to_dsp(V2_to_dsp),
    .valid_from_cdb(valid_from_cdb), .Q_from_cdb(Q_from_cdb), .V_from_cdb(V_from_cdb),
    .jump_from_cdb(jump_from_cdb), .pc_from_cdb(pc_from_cdb),
    .commit_flag_to_reg(commit_flag_to_reg), .rd_to_reg(rd_to_reg),
    .Q_to_reg(Q_to_reg), .V_to_reg(V_to_reg),
    .rollback_flag_to_all(rollback_flag_to_all), .target_pc_to_if(target_pc_to_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: program-order list of in-flight instructions
  typedef struct {
    logic [ROB_ID_W-1:0] tag;
    logic [4:0]          rd;
    logic                is_jump, pred, ready, jump;
    logic [DATA_W-1:0]   v, pc;
  } ent_t;
  ent_t exp_q[$];
  int                  model_tail;
  logic                exp_commit, exp_rollback;
  logic [4:0]          exp_rd;
  logic [ROB_ID_W-1:0] exp_tag;
  logic [DATA_W-1:0]   exp_v, exp_tpc;

  task automatic model_reset();
    exp_q.delete();
    model_tail = 1;
    exp_commit = 1'b0; exp_rollback = 1'b0;
    exp_rd = '0; exp_tag = '0; exp_v = '0; exp_tpc = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    bit do_commit, do_mis;
    int pre_size;
    ent_t e;
    exp_commit = 1'b0; exp_rollback = 1'b0; do_mis = 1'b0;
    pre_size  = exp_q.size();
    do_commit = (pre_size > 0) && exp_q[0].ready;
    if (do_commit) begin
      exp_commit = 1'b1; exp_rd = exp_q[0].rd; exp_tag = exp_q[0].tag; exp_v = exp_q[0].v;
      do_mis = exp_q[0].is_jump && (exp_q[0].jump != exp_q[0].pred);
      if (do_mis) begin exp_rollback = 1'b1; exp_tpc = exp_q[0].pc; end
    end
    if (valid_from_cdb) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (exp_q[i].tag == Q_from_cdb) begin
          e = exp_q[i]; e.ready = 1'b1; e.v = V_from_cdb; e.jump = jump_from_cdb; e.pc = pc_from_cdb;
          exp_q[i] = e;
        end
      end
    end
    if (do_commit) void'(exp_q.pop_front());
    if (do_mis) begin
      exp_q.delete();
      model_tail = 1;
    end else if (ena_from_dsp && pre_size < DEPTH) begin
      e.tag = ROB_ID_W'(model_tail); e.rd = rd_from_dsp; e.is_jump = is_jump_from_dsp;
      e.pred = pred_jump_from_dsp; e.ready = 1'b0; e.jump = 1'b0; e.v = '0; e.pc = '0;
      exp_q.push_back(e);
      model_tail = (model_tail == DEPTH) ? 1 : model_tail + 1;
    end
  endtask

  // Expected query answer from the model's view of the buffer
  task automatic exp_query(input logic [ROB_ID_W-1:0] q, output logic r, output logic [DATA_W-1:0] v);
    r = 1'b0; v = '0;
    if (q == '0) begin
      r = 1'b1;
    end else begin
      foreach (exp_q[i]) begin
        if (exp_q[i].tag == q) begin
          if (exp_q[i].ready) begin r = 1'b1; v = exp_q[i].v; end
          else if (BYP && valid_from_cdb && Q_from_cdb == q) begin r = 1'b1; v = V_from_cdb; end
        end
      end
    end
  endtask

  // Driver tasks
  task automatic set_idle();
    ena_from_dsp = 1'b0; rd_from_dsp = '0; is_jump_from_dsp = 1'b0; pred_jump_from_dsp = 1'b0;
    Q1_from_dsp = '0; Q2_from_dsp = '0;
    valid_from_cdb = 1'b0; Q_from_cdb = '0; V_from_cdb = '0; jump_from_cdb = 1'b0; pc_from_cdb = '0;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic isj, input logic pred);
    ena_from_dsp = 1'b1; rd_from_dsp = rd; is_jump_from_dsp = isj; pred_jump_from_dsp = pred;
  endtask

  task automatic cdb(input logic [ROB_ID_W-1:0] q, input logic [DATA_W-1:0] v,
                     input logic j, input logic [DATA_W-1:0] pc);
    valid_from_cdb = 1'b1; Q_from_cdb = q; V_from_cdb = v; jump_from_cdb = j; pc_from_cdb = pc;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    model_reset();
    #1 rst = 1'b0;
    #1;
    n_checks++; if (commit_flag_to_reg !== 1'b0) begin n_fail++; $display("FAIL reset_commit: got %0b want 0", commit_flag_to_reg); end
    n_checks++; if (rollback_flag_to_all !== 1'b0) begin n_fail++; $display("FAIL reset_rollback: got %0b want 0", rollback_flag_to_all); end
    n_checks++; if (Q_to_dsp !== 4'd1) begin n_fail++; $display("FAIL reset_q_to_dsp: got %0d want 1", Q_to_dsp); end
    n_checks++; if (full_to_dsp !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b want 0", full_to_dsp); end
    n_checks++; if ({rd_to_reg, Q_to_reg, V_to_reg, target_pc_to_if} !== '0) begin n_fail++; $display("FAIL reset_outputs: rd=%0d q=%0d v=%0h pc=%0h want all 0", rd_to_reg, Q_to_reg, V_to_reg, target_pc_to_if); end
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_basic_commit();
    do_reset();
    alloc(5'd5, 1'b0, 1'b0);
    #1;
    n_checks++; if (Q_to_dsp !== 4'd1) begin n_fail++; $display("FAIL basic_first_tag: got %0d want 1", Q_to_dsp); end
    tick();
    n_checks++; if (Q_to_dsp !== 4'd2) begin n_fail++; $display("FAIL basic_second_tag: got %0d want 2", Q_to_dsp); end
    set_idle(); cdb(4'd1, 32'h1234, 1'b0, '0);
    tick();
    n_checks++; if (commit_flag_to_reg !== 1'b0) begin n_fail++; $display("FAIL basic_no_same_edge_commit: got %0b want 0", commit_flag_to_reg); end
    set_idle();
    tick();
    n_checks++; if (commit_flag_to_reg !== 1'b1) begin n_fail++; $display("FAIL basic_commit_flag: got %0b want 1", commit_flag_to_reg); end
    n_checks++; if ({rd_to_reg, Q_to_reg, V_to_reg} !== {5'd5, 4'd1, 32'h1234}) begin n_fail++; $display("FAIL basic_commit_data: rd=%0d q=%0d v=%0h want rd=5 q=1 v=1234", rd_to_reg, Q_to_reg, V_to_reg); end
    tick();
    n_checks++; if (commit_flag_to_reg !== 1'b0 || rd_to_reg !== 5'd5) begin n_fail++; $display("FAIL basic_pulse_hold: flag=%0b rd=%0d want flag=0 rd=5", commit_flag_to_reg, rd_to_reg); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_idle(); alloc(5'(i + 1), 1'b0, 1'b0);
      tick();
      if (i == DEPTH - 2) begin
        n_checks++; if (full_to_dsp !== 1'b0) begin n_fail++; $display("FAIL full_one_short: got %0b want 0", full_to_dsp); end
      end
    end
    n_checks++; if (full_to_dsp !== 1'b1 || Q_to_dsp !== 4'd1) begin n_fail++; $display("FAIL full_set: full=%0b tag=%0d want full=1 tag=1", full_to_dsp, Q_to_dsp); end
    set_idle(); alloc(5'd20, 1'b0, 1'b0);
    tick();
    n_checks++; if (full_to_dsp !== 1'b1 || Q_to_dsp !== 4'd1) begin n_fail++; $display("FAIL full_ignore_ena: full=%0b tag=%0d want full=1 tag=1", full_to_dsp, Q_to_dsp); end
    set_idle(); alloc(5'd21, 1'b0, 1'b0); cdb(4'd1, 32'hAA, 1'b0, '0);
    tick();
    set_idle(); alloc(5'd22, 1'b0, 1'b0);
    tick();
    n_checks++; if (commit_flag_to_reg !== 1'b1 || Q_to_reg !== 4'd1) begin n_fail++; $display("FAIL full_commit: flag=%0b q=%0d want flag=1 q=1", commit_flag_to_reg, Q_to_reg); end
    n_checks++; if (full_to_dsp !== 1'b0 || Q_to_dsp !== 4'd1) begin n_fail++; $display("FAIL full_refused_at_commit: full=%0b tag=%0d want full=0 tag=1", full_to_dsp, Q_to_dsp); end
    set_idle(); alloc(5'd23, 1'b0, 1'b0);
    tick();
    n_checks++; if (full_to_dsp !== 1'b1 || Q_to_dsp !== 4'd2) begin n_fail++; $display("FAIL full_wrap_reuse: full=%0b tag=%0d want full=1 tag=2", full_to_dsp, Q_to_dsp); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_idle(); alloc(5'd1, 1'b0, 1'b0); tick();
    set_idle(); alloc(5'd2, 1'b0, 1'b0); tick();
    set_idle(); cdb(4'd2, 32'h22, 1'b0, '0); tick();
    set_idle(); tick();
    n_checks++; if (commit_flag_to_reg !== 1'b0) begin n_fail++; $display("FAIL ooo_wait_head: got %0b want 0", commit_flag_to_reg); end
    set_idle(); cdb(4'd1, 32'h11, 1'b0, '0); tick();
    set_idle(); tick();
    n_checks++; if (commit_flag_to_reg !== 1'b1 || Q_to_reg !== 4'd1 || V_to_reg !== 32'h11) begin n_fail++; $display("FAIL ooo_commit1: flag=%0b q=%0d v=%0h want 1/1/11", commit_flag_to_reg, Q_to_reg, V_to_reg); end
    tick();
    n_checks++; if (commit_flag_to_reg !== 1'b1 || Q_to_reg !== 4'd2 || V_to_reg !== 32'h22 || rd_to_reg !== 5'd2) begin n_fail++; $display("FAIL ooo_commit2: flag=%0b q=%0d v=%0h rd=%0d want 1/2/22/2", commit_flag_to_reg, Q_to_reg, V_to_reg, rd_to_reg); end
    tick();
    n_checks++; if (commit_flag_to_reg !== 1'b0) begin n_fail++; $display("FAIL ooo_drained: got %0b want 0", commit_flag_to_reg); end
  endtask

  task automatic test_mispredict();
    do_reset();
    set_idle(); alloc(5'd0, 1'b1, 1'b0); tick();
    set_idle(); alloc(5'd3, 1'b0, 1'b0); tick();
    set_idle(); alloc(5'd4, 1'b0, 1'b0); cdb(4'd2, 32'h55, 1'b0, '0); tick();
    set_idle(); cdb(4'd1, 32'h0, 1'b1, 32'h80); tick();
    set_idle(); alloc(5'd7, 1'b0, 1'b0); Q1_from_dsp = 4'd2;
    #1;
    n_checks++; if (ready1_to_dsp !== 1'b1 || V1_to_dsp !== 32'h55) begin n_fail++; $display("FAIL misp_query_before: ready=%0b v=%0h want 1/55", ready1_to_dsp, V1_to_dsp); end
    tick();
    n_checks++; if (commit_flag_to_reg !== 1'b1 || rollback_flag_to_all !== 1'b1 || target_pc_to_if !== 32'h80 || Q_to_reg !== 4'd1) begin n_fail++; $display("FAIL misp_rollback: c=%0b rb=%0b pc=%0h q=%0d want 1/1/80/1", commit_flag_to_reg, rollback_flag_to_all, target_pc_to_if, Q_to_reg); end
    n_checks++; if (Q_to_dsp !== 4'd1 || full_to_dsp !== 1'b0) begin n_fail++; $display("FAIL misp_pointers: tag=%0d full=%0b want 1/0", Q_to_dsp, full_to_dsp); end
    set_idle(); Q1_from_dsp = 4'd2; Q2_from_dsp = 4'd3;
    #1;
    n_checks++; if (ready1_to_dsp !== 1'b0 || V1_to_dsp !== '0 || ready2_to_dsp !== 1'b0) begin n_fail++; $display("FAIL misp_flushed: r1=%0b v1=%0h r2=%0b want 0/0/0", ready1_to_dsp, V1_to_dsp, ready2_to_dsp); end
    tick();
    n_checks++; if (commit_flag_to_reg !== 1'b0 || rollback_flag_to_all !== 1'b0) begin n_fail++; $display("FAIL misp_one_cycle: c=%0b rb=%0b want 0/0", commit_flag_to_reg, rollback_flag_to_all); end
    set_idle(); alloc(5'd8, 1'b0, 1'b0); tick();
    n_checks++; if (Q_to_dsp !== 4'd2) begin n_fail++; $display("FAIL misp_realloc: tag=%0d want 2", Q_to_dsp); end
  endtask

  task automatic test_query_bypass();
    do_reset();
    for (int i = 0; i < 3; i++) begin set_idle(); alloc(5'(i + 9), 1'b0, 1'b0); tick(); end
    set_idle(); Q1_from_dsp = 4'd3; Q2_from_dsp = 4'd0; cdb(4'd3, 32'd7, 1'b0, '0);
    #1;
    n_checks++; if (ready1_to_dsp !== BYP || V1_to_dsp !== (BYP ? 32'd7 : 32'd0)) begin n_fail++; $display("FAIL query_same_cycle: ready=%0b v=%0h want %0b/%0h", ready1_to_dsp, V1_to_dsp, BYP, BYP ? 32'd7 : 32'd0); end
    n_checks++; if (ready2_to_dsp !== 1'b1 || V2_to_dsp !== '0) begin n_fail++; $display("FAIL query_tag0: ready=%0b v=%0h want 1/0", ready2_to_dsp, V2_to_dsp); end
    tick();
    set_idle(); Q1_from_dsp = 4'd3; Q2_from_dsp = 4'd1;
    #1;
    n_checks++; if (ready1_to_dsp !== 1'b1 || V1_to_dsp !== 32'd7) begin n_fail++; $display("FAIL query_stored: ready=%0b v=%0h want 1/7", ready1_to_dsp, V1_to_dsp); end
    n_checks++; if (ready2_to_dsp !== 1'b0 || V2_to_dsp !== '0) begin n_fail++; $display("FAIL query_pending: ready=%0b v=%0h want 0/0", ready2_to_dsp, V2_to_dsp); end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    set_idle(); alloc(5'd9, 1'b0, 1'b0); tick();
    set_idle(); cdb(4'd1, 32'hBEEF, 1'b0, '0); tick();
    set_idle(); tick();
    n_checks++; if (commit_flag_to_reg !== 1'b1 || V_to_reg !== 32'hBEEF) begin n_fail++; $display("FAIL async_pre: flag=%0b v=%0h want 1/beef", commit_flag_to_reg, V_to_reg); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (commit_flag_to_reg !== 1'b0 || V_to_reg !== '0 || rd_to_reg !== '0) begin n_fail++; $display("FAIL async_outputs: flag=%0b v=%0h rd=%0d want 0", commit_flag_to_reg, V_to_reg, rd_to_reg); end
    n_checks++; if (Q_to_dsp !== 4'd1 || full_to_dsp !== 1'b0) begin n_fail++; $display("FAIL async_pointers: tag=%0d full=%0b want 1/0", Q_to_dsp, full_to_dsp); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_random();
    logic er1, er2;
    logic [DATA_W-1:0] ev1, ev2;
    int pend[$];
    int r, k, stray;
    bit in_q;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      set_idle();
      if ($urandom_range(0, 9) < 7) alloc(5'($urandom_range(0, 31)), ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
      V_from_cdb = $urandom; pc_from_cdb = $urandom; jump_from_cdb = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      pend.delete();
      foreach (exp_q[i]) if (!exp_q[i].ready) pend.push_back(i);
      if (r < 5 && pend.size() > 0) begin
        k = pend[$urandom_range(0, pend.size() - 1)];
        valid_from_cdb = 1'b1; Q_from_cdb = exp_q[k].tag;
        if ($urandom_range(0, 3) != 0) jump_from_cdb = exp_q[k].pred;
      end else if (r == 5) begin
        stray = $urandom_range(0, 15); in_q = 1'b0;
        foreach (exp_q[i]) if (exp_q[i].tag == ROB_ID_W'(stray)) in_q = 1'b1;
        if (!in_q) begin valid_from_cdb = 1'b1; Q_from_cdb = ROB_ID_W'(stray); end
      end
      Q1_from_dsp = ROB_ID_W'($urandom_range(0, 15));
      Q2_from_dsp = ROB_ID_W'($urandom_range(0, 15));
      #1;
      exp_query(Q1_from_dsp, er1, ev1);
      exp_query(Q2_from_dsp, er2, ev2);
      n_checks++; if (ready1_to_dsp !== er1 || V1_to_dsp !== ev1) begin n_fail++; $display("FAIL rnd_query1 cyc %0d tag %0d: got %0b/%0h want %0b/%0h", c, Q1_from_dsp, ready1_to_dsp, V1_to_dsp, er1, ev1); end
      n_checks++; if (ready2_to_dsp !== er2 || V2_to_dsp !== ev2) begin n_fail++; $display("FAIL rnd_query2 cyc %0d tag %0d: got %0b/%0h want %0b/%0h", c, Q2_from_dsp, ready2_to_dsp, V2_to_dsp, er2, ev2); end
      tick();
      n_checks++; if (commit_flag_to_reg !== exp_commit || rollback_flag_to_all !== exp_rollback) begin n_fail++; $display("FAIL rnd_flags cyc %0d: got c=%0b rb=%0b want c=%0b rb=%0b", c, commit_flag_to_reg, rollback_flag_to_all, exp_commit, exp_rollback); end
      n_checks++; if (rd_to_reg !== exp_rd || Q_to_reg !== exp_tag || V_to_reg !== exp_v) begin n_fail++; $display("FAIL rnd_commit_data cyc %0d: got rd=%0d q=%0d v=%0h want rd=%0d q=%0d v=%0h", c, rd_to_reg, Q_to_reg, V_to_reg, exp_rd, exp_tag, exp_v); end
      n_checks++; if (target_pc_to_if !== exp_tpc) begin n_fail++; $display("FAIL rnd_target_pc cyc %0d: got %0h want %0h", c, target_pc_to_if, exp_tpc); end
      n_checks++; if (Q_to_dsp !== ROB_ID_W'(model_tail) || full_to_dsp !== (exp_q.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_alloc_state cyc %0d: got tag=%0d full=%0b want tag=%0d full=%0b", c, Q_to_dsp, full_to_dsp, model_tail, exp_q.size() == DEPTH); end
    end
  endtask

  // Test sequence and final report
  initial begin
    set_idle();
    model_reset();
    test_reset();
    test_basic_commit();
    test_full_wrap();
    test_back_to_back();
    test_mispredict();
    test_query_bypass();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
